// File: rtl/auto_nav_decider_pkg.sv
// Shared definitions for the autonomous navigation decider: FSM state
// encoding, turn-direction enum, default timing constants and the
// direction-priority helper.
// Build option: define AUTO_NAV_LEFT_HAND_EN to select the left-hand rule
// (left, front, right, back); otherwise the right-hand rule is used.
package auto_nav_decider_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 5;    // 10 ms at 500 Hz
  localparam int DEF_COOLDOWN_CYCLES = 250;  // 0.5 s at 500 Hz
  localparam int DEF_ACK_TIMEOUT     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_FORWARD,
    ST_FIRE,
    ST_WAIT_ACK,
    ST_WAIT_TURN,
    ST_COOLDOWN
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_LEFT,
    DIR_RIGHT,
    DIR_BACK
  } turn_dir_e;

  // Picks the turn from debounced "blocked" flags; DIR_NONE keeps driving straight.
  function automatic turn_dir_e pick_turn(input logic front_blk,
                                          input logic left_blk,
                                          input logic right_blk);
`ifdef AUTO_NAV_LEFT_HAND_EN
    if (!left_blk)       return DIR_LEFT;
    else if (!front_blk) return DIR_NONE;
    else if (!right_blk) return DIR_RIGHT;
    else                 return DIR_BACK;
`else
    if (!right_blk)      return DIR_RIGHT;
    else if (!front_blk) return DIR_NONE;
    else if (!left_blk)  return DIR_LEFT;
    else                 return DIR_BACK;
`endif
  endfunction

endpackage

// File: rtl/auto_nav_decider_detector_debounce.sv
// detector_debounce: 2-flop synchronizer followed by a debouncer. The
// output follows the synchronized input only after DEBOUNCE_CYCLES
// consecutive samples that differ from the current output.
module detector_debounce
  import auto_nav_decider_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  // Synchronize the raw detector and accept a new level once it has held long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the synchronizer and debounced level reset to 1 so a detector
      // reads "blocked" until proven otherwise; a 0 reset would look like an
      // open path and could fire a turn straight out of reset.
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments make r_sync2 take the old r_sync1,
      // giving a real two-stage chain; blocking ones would collapse it.
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/auto_nav_decider.sv
// auto_nav_decider: debounces three obstacle detectors and decides when to
// request a turn from the downstream turning stage, then waits for the
// turn to be acknowledged and completed, followed by a straight cooldown.
// Build option: AUTO_NAV_LEFT_HAND_EN selects the left-hand turn priority.
module auto_nav_decider
  import auto_nav_decider_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter int ACK_TIMEOUT     = DEF_ACK_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic detect_front,
  input  logic detect_left,
  input  logic detect_right,
  input  logic is_turning,
  output logic trigger_turn_left,
  output logic trigger_turn_right,
  output logic trigger_turn_back,
  output logic move_forward,
  output logic ack_fault
);

  // One counter serves SETTLE, WAIT_ACK and COOLDOWN; it is cleared on every state entry.
  localparam int CNT_MAX_A = (COOLDOWN_CYCLES > DEBOUNCE_CYCLES + 2) ? COOLDOWN_CYCLES
                                                                     : DEBOUNCE_CYCLES + 2;
  localparam int CNT_MAX   = (CNT_MAX_A > ACK_TIMEOUT) ? CNT_MAX_A : ACK_TIMEOUT;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] COOL_LAST   = CNT_W'(COOLDOWN_CYCLES - 1);

  logic             w_front;
  logic             w_left;
  logic             w_right;
  turn_dir_e        w_dir;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_trig_left;
  logic             r_trig_right;
  logic             r_trig_back;
  logic             r_move_fwd;
  logic             r_ack_fault;
  logic             r_enable_d;

  detector_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_front (
    .clk(clk), .rst_n(rst_n), .i_async(detect_front), .o_level(w_front)
  );
  detector_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(clk), .rst_n(rst_n), .i_async(detect_left), .o_level(w_left)
  );
  detector_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(clk), .rst_n(rst_n), .i_async(detect_right), .o_level(w_right)
  );

  assign w_dir = pick_turn(w_front, w_left, w_right);

  // Decision FSM with registered outputs; each output is set on the edge that enters its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_trig_left  <= 1'b0;
      r_trig_right <= 1'b0;
      r_trig_back  <= 1'b0;
      r_move_fwd   <= 1'b0;
      r_ack_fault  <= 1'b0;
      r_enable_d   <= 1'b0;
    end else begin
      r_enable_d   <= enable;
      // Triggers are single-cycle pulses: low unless raised on the FORWARD->FIRE edge.
      r_trig_left  <= 1'b0;
      r_trig_right <= 1'b0;
      r_trig_back  <= 1'b0;
      if (!enable) begin
        r_state    <= ST_IDLE;
        r_cnt      <= '0;
        r_move_fwd <= 1'b0;
      end else begin
        if (!r_enable_d) r_ack_fault <= 1'b0;
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_SETTLE;
            r_cnt   <= '0;
          end
          ST_SETTLE: begin
            if (r_cnt == SETTLE_LAST) begin
              r_state    <= ST_FORWARD;
              r_cnt      <= '0;
              r_move_fwd <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_FORWARD: begin
            r_trig_left  <= (w_dir == DIR_LEFT);
            r_trig_right <= (w_dir == DIR_RIGHT);
            r_trig_back  <= (w_dir == DIR_BACK);
            r_move_fwd   <= (w_dir == DIR_NONE);
            if (w_dir != DIR_NONE) r_state <= ST_FIRE;
          end
          ST_FIRE: begin
            r_state <= ST_WAIT_ACK;
            r_cnt   <= '0;
          end
          ST_WAIT_ACK: begin
            if (is_turning) begin
              r_state <= ST_WAIT_TURN;
            end else if (r_cnt == ACK_LAST) begin
              r_ack_fault <= 1'b1;
              r_state     <= ST_FORWARD;
              r_cnt       <= '0;
              r_move_fwd  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_WAIT_TURN: begin
            if (!is_turning) begin
              r_state    <= ST_COOLDOWN;
              r_cnt      <= '0;
              r_move_fwd <= 1'b1;
            end
          end
          ST_COOLDOWN: begin
            if (r_cnt == COOL_LAST) begin
              r_state <= ST_FORWARD;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_move_fwd <= 1'b0;
          end
        endcase
      end
    end
  end

  assign trigger_turn_left  = r_trig_left;
  assign trigger_turn_right = r_trig_right;
  assign trigger_turn_back  = r_trig_back;
  assign move_forward       = r_move_fwd;
  assign ack_fault          = r_ack_fault;

endmodule

// File: doc/auto_nav_decider.md
AUTO_NAV_DECIDER -- requirements
Module: auto_nav_decider

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 5: cycles a detector input must hold stable before acceptance (10 ms at 500 Hz).
REQ-002 SHALL have parameter COOLDOWN_CYCLES, default 250: forward-only cycles after a turn before the next decision (0.5 s).
REQ-003 SHALL have parameter ACK_TIMEOUT, default 8: cycles allowed for is_turning to assert after a trigger.
REQ-004 clk  input  1  500 Hz system clock; the block's only clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 enable  input  1  auto-drive mode enable.
REQ-007 detect_front, detect_left, detect_right  input  1 each  asynchronous obstacle detectors; 1 = blocked.
REQ-008 is_turning  input  1  busy flag from the downstream turning stage.
REQ-009 trigger_turn_left, trigger_turn_right, trigger_turn_back  output  1 each  single-cycle turn requests to the turning stage.
REQ-010 move_forward  output  1  high while the car drives straight.
REQ-011 ack_fault  output  1  sticky flag: turning stage failed to acknowledge a trigger.

Function
REQ-012 SHALL pass each detector through a 2-flop synchronizer, then a debouncer; the debounced value updates only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-013 SHALL implement FSM states IDLE, SETTLE, FORWARD, FIRE, WAIT_ACK, WAIT_TURN, COOLDOWN.
REQ-014 IDLE -> SETTLE when enable=1; SETTLE holds DEBOUNCE_CYCLES+2 cycles, then -> FORWARD.
REQ-015 In FORWARD, each cycle, using the debounced values: right open -> FIRE(right); else front open -> stay in FORWARD; else left open -> FIRE(left); else FIRE(back).
REQ-016 FIRE SHALL last exactly one cycle, asserting exactly one trigger; triggers SHALL be one-hot or all zero in every cycle.
REQ-017 FIRE -> WAIT_ACK; WAIT_ACK -> WAIT_TURN when is_turning=1; if is_turning stays 0 for ACK_TIMEOUT cycles, set ack_fault and -> FORWARD.
REQ-018 WAIT_TURN -> COOLDOWN on the first cycle is_turning=0; detector changes during WAIT_ACK/WAIT_TURN SHALL be ignored.
REQ-019 COOLDOWN SHALL count COOLDOWN_CYCLES, then -> FORWARD; the counter SHALL be cleared on every entry and never wrap.
REQ-020 move_forward SHALL be 1 in FORWARD (no fire decision) and COOLDOWN, 0 otherwise.
REQ-021 FORWARD->FIRE decision to trigger pulse latency: exactly 1 cycle (registered outputs).
REQ-022 enable=0 in any state SHALL force IDLE on the next edge with all triggers and move_forward 0; ack_fault is retained.
REQ-023 ack_fault SHALL clear only on reset or on an enable 0->1 transition.

Reset
REQ-024 rst_n=0 SHALL asynchronously force IDLE, all outputs 0, all counters 0, debounced detectors 1 (blocked), synchronizer flops 1.
REQ-025 Reset asserted mid-turn SHALL abort any pending trigger; no trigger may be issued in the first cycle after release.

Configuration
REQ-026 Macro AUTO_NAV_LEFT_HAND_EN defined: the REQ-015 priority becomes left, front, right, back (left-hand rule); undefined: right-hand rule as in REQ-015.

Structure
REQ-027 Shared package SHALL hold the FSM state encoding, the turn-direction enum (NONE, LEFT, RIGHT, BACK) and default timing constants.
REQ-028 Sub-module detector_debounce (synchronizer + debounce counter, parameter DEBOUNCE_CYCLES) SHALL be instantiated three times.

Verification
REQ-029 enable=1, front=1, right=0 stable -> after SETTLE, one-cycle trigger_turn_right=1; is_turning held 750 cycles -> COOLDOWN 250 cycles with move_forward=1, then FORWARD.
REQ-030 front=1, left=1, right=1 -> trigger_turn_back single pulse; other triggers 0 throughout.
REQ-031 Detector glitch of 3 cycles (< DEBOUNCE_CYCLES) in FORWARD -> no trigger, move_forward stays 1.
REQ-032 Trigger issued, is_turning never asserts -> ack_fault=1 after 8 cycles, return to FORWARD; enable toggle 0->1 clears ack_fault.
REQ-033 rst_n pulsed low during WAIT_TURN -> outputs 0 immediately; enable low mid-COOLDOWN -> IDLE next edge; with AUTO_NAV_LEFT_HAND_EN and left=0, right=0, front=1 -> trigger_turn_left.
